fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 imem_addr  output  16  instruction memory word address, equal to PC.
REQ-004 imem_rd  output  1  read request, held high with stable imem_addr until imem_ready.
REQ-005 imem_data  input  16  instruction word, valid only in a cycle with imem_rd=1 and imem_ready=1.
REQ-006 imem_ready  input  1  memory completion strobe; may arrive 0..N cycles after imem_rd rises.
REQ-007 instruc  output  16  registered instruction presented to the decoder.
REQ-008 pc_plus2  output  16  registered address of the presented instruction plus 2.
REQ-009 instr_valid  output  1  instruc and pc_plus2 are valid.
REQ-010 stall  input  1  downstream hazard; presented instruction is not consumed this cycle.
REQ-011 en_PC  input  1  decoder PC enable for the presented instruction; 0 means HALT.
REQ-012 redirect  input  1  presented instruction is a taken branch or jump.
REQ-013 redirect_pc  input  16  target PC for redirect; bit 0 is ignored.
REQ-014 halted  output  1  sticky halt indicator.

Function
REQ-015 The block SHALL implement three states: REQ (fetching), HOLD (instruction presented), and HALT.
REQ-016 The presented instruction SHALL be consumed in a cycle when state=HOLD and stall=0.
REQ-017 en_PC, redirect and redirect_pc SHALL be sampled only in a consume cycle and ignored otherwise.
REQ-018 In REQ, imem_rd SHALL be 1, imem_addr SHALL equal PC, and instr_valid SHALL be 0.
REQ-019 On REQ with imem_ready=1, the block SHALL register instruc<=imem_data, set pc_plus2<=PC+2 and PC<=PC+2, and enter HOLD.
REQ-020 PC+2 SHALL wrap modulo 2^16, so 0xFFFE+2 gives 0x0000.
REQ-021 In HOLD, imem_rd SHALL be 0, instr_valid SHALL be 1, and instruc/pc_plus2 SHALL be held stable while stall=1.
REQ-022 On consume with en_PC=0, the block SHALL enter HALT; redirect is ignored in this case.
REQ-023 On consume with en_PC=1 and redirect=1, the block SHALL set PC<={redirect_pc[15:1],1'b0} and enter REQ.
REQ-024 On consume with en_PC=1 and redirect=0, the block SHALL enter REQ with PC unchanged, since PC is already +2.
REQ-025 Priority on consume SHALL be: halt, then redirect, then sequential.
REQ-026 In HALT, the block SHALL drive imem_rd=0, instr_valid=0 and halted=1, and SHALL leave HALT only on reset.
REQ-027 The minimum fetch cycle SHALL be 2 clocks per instruction: one REQ cycle with immediate ready, then one HOLD cycle.
REQ-028 In REQ, the stall, redirect and en_PC inputs SHALL have no effect.
REQ-029 PC[0] SHALL always be 0.

Reset
REQ-030 While rst=1, the block SHALL force state=REQ, PC=0x0000, instruc=0x0000, pc_plus2=0x0000, instr_valid=0 and halted=0, independent of clk.
REQ-031 Reset SHALL abort a fetch in flight; the block SHALL discard imem_ready/imem_data seen during reset.
REQ-032 On the first clock edge after rst falls, the block SHALL be in REQ with imem_rd=1 and imem_addr=0x0000.
REQ-033 Reset asserted in HOLD or HALT SHALL clear instr_valid and halted asynchronously.

Verification
REQ-034 Sequential fetch: reset, imem_ready tied 1, memory returning 0x1000+addr, stall=0, en_PC=1, redirect=0 -> instr_valid pulses every 2nd cycle; instruc = 0x1000, 0x1002, 0x1004; pc_plus2 = 0x0002, 0x0004, 0x0006.
REQ-035 Wait states: imem_ready asserted 3 cycles after imem_rd -> imem_addr is stable for all 4 request cycles, and instr_valid rises the cycle after ready.
REQ-036 Stall: hold stall=1 for 5 cycles in HOLD -> instruc and pc_plus2 are unchanged, imem_rd=0, and the next fetch starts the cycle after stall falls.
REQ-037 Redirect: consume the instruction at 0x0004 with redirect=1 and redirect_pc=0x0031 -> next imem_addr=0x0030; redirect asserted while stall=1 has no effect.
REQ-038 Halt: consume with en_PC=0 and redirect=1 -> HALT, halted=1 and imem_rd=0 permanently; an async rst pulse mid-cycle returns to REQ at 0x0000.
REQ-039 Wrap: redirect to 0xFFFE -> pc_plus2=0x0000 and next imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: requests one 16-bit word from instruction memory, presents it to
// the decoder together with its return address, and waits for the decoder to consume it,
// redirect the PC, or halt the machine.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_ready,
    output logic [15:0] instruc,
    output logic [15:0] pc_plus2,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        en_PC,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StHold = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic [15:0] pc_inc;
    logic        consume;

    // PC is kept word-aligned, so +2 never disturbs bit 0 and wraps naturally at 16 bits.
    assign pc_inc  = pc_q + 16'd2;
    assign consume = (state_q == StHold) && !stall;

    // State and datapath registers; reset aborts any fetch in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= 16'h0000;
            instr_q    <= 16'h0000;
            pc_plus2_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
        end
    end

    // Next-state logic: decoder controls are only looked at in a consume cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        unique case (state_q)
            StReq: begin
                if (imem_ready) begin
                    instr_d    = imem_data;
                    pc_plus2_d = pc_inc;
                    pc_d       = pc_inc;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (consume) begin
                    if (!en_PC) begin
                        // Halt wins over any redirect on the same instruction.
                        state_d = StHalt;
                    end else if (redirect) begin
                        pc_d    = redirect_pc & 16'hFFFE;
                        state_d = StReq;
                    end else begin
                        // PC already points past the presented instruction.
                        state_d = StReq;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StReq;
            end
        endcase
    end

    // Outputs decode directly from the state register so reset clears them asynchronously.
    always_comb begin
        imem_rd     = (state_q == StReq);
        instr_valid = (state_q == StHold);
        halted      = (state_q == StHalt);
        imem_addr   = pc_q;
        instruc     = instr_q;
        pc_plus2    = pc_plus2_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a scoreboard of expected (instruction, pc_plus2) pairs
// is filled as fetches are set up and drained by a monitor whenever a new instruction appears.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data;
    logic        imem_ready;
    logic [15:0] instruc;
    logic [15:0] pc_plus2;
    logic        instr_valid;
    logic        stall;
    logic        en_PC;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pcp2;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_valid;
    int   tests;
    int   fails;

    fetch_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .instruc    (instruc),
        .pc_plus2   (pc_plus2),
        .instr_valid(instr_valid),
        .stall      (stall),
        .en_PC      (en_PC),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word at address A holds 0x1000 + A.
    always_comb imem_data = 16'h1000 + imem_addr;

    function automatic void push_exp(input logic [15:0] instr, input logic [15:0] pcp2);
        exp_t e;
        e.instr = instr;
        e.pcp2  = pcp2;
        sb.push_back(e);
    endfunction

    // Monitor: each rising edge of instr_valid is a newly presented instruction.
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && prev_valid === 1'b0) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got instruc=%h pc_plus2=%h, want nothing", instruc,
                         pc_plus2);
            end else begin
                mon_e = sb.pop_front();
                tests++;
                if (instruc !== mon_e.instr) begin
                    fails++;
                    $display("FAIL sb_instruc: got %h, want %h", instruc, mon_e.instr);
                end
                if (pc_plus2 !== mon_e.pcp2) begin
                    fails++;
                    $display("FAIL sb_pc_plus2: got %h, want %h", pc_plus2, mon_e.pcp2);
                end
            end
        end
        prev_valid <= instr_valid;
    end

    task automatic test_reset();
        // Memory is ready with data throughout reset; it must be discarded.
        repeat (2) @(negedge clk);
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, want 0", instr_valid); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rst_halted: got %b, want 0", halted); end
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL rst_rd: got %b, want 1", imem_rd); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL rst_addr: got %h, want 0000", imem_addr); end
        tests++; if (instruc !== 16'h0000) begin fails++; $display("FAIL rst_instruc: got %h, want 0000", instruc); end
        tests++; if (pc_plus2 !== 16'h0000) begin fails++; $display("FAIL rst_pc_plus2: got %h, want 0000", pc_plus2); end
        rst        = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL post_rst_rd: got %b, want 1", imem_rd); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL post_rst_addr: got %h, want 0000", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL post_rst_valid: got %b, want 0", instr_valid); end
    endtask

    task automatic test_sequential();
        logic exp_v;
        push_exp(16'h1000, 16'h0002);
        push_exp(16'h1002, 16'h0004);
        push_exp(16'h1004, 16'h0006);
        imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_v = (i % 2 == 0) ? 1'b1 : 1'b0;
            tests++; if (instr_valid !== exp_v) begin fails++; $display("FAIL seq_valid[%0d]: got %b, want %b", i, instr_valid, exp_v); end
        end
        tests++; if (imem_addr !== 16'h0006) begin fails++; $display("FAIL seq_next_addr: got %h, want 0006", imem_addr); end
        imem_ready = 1'b0;
        #1;
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL seq_drained: got %0d pending, want 0", sb.size()); end
    endtask

    task automatic test_wait_states();
        // Stall, halt and redirect requests are all asserted during REQ and must be ignored.
        stall       = 1'b1;
        en_PC       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        push_exp(16'h1006, 16'h0008);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL ws_rd[%0d]: got %b, want 1", k, imem_rd); end
            tests++; if (imem_addr !== 16'h0006) begin fails++; $display("FAIL ws_addr[%0d]: got %h, want 0006", k, imem_addr); end
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL ws_valid[%0d]: got %b, want 0", k, instr_valid); end
            if (k == 3) imem_ready = 1'b1;
        end
        @(negedge clk);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL ws_valid_after_ready: got %b, want 1", instr_valid); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL stall_valid[%0d]: got %b, want 1", i, instr_valid); end
            tests++; if (instruc !== 16'h1006) begin fails++; $display("FAIL stall_instruc[%0d]: got %h, want 1006", i, instruc); end
            tests++; if (pc_plus2 !== 16'h0008) begin fails++; $display("FAIL stall_pc_plus2[%0d]: got %h, want 0008", i, pc_plus2); end
            tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL stall_rd[%0d]: got %b, want 0", i, imem_rd); end
            tests++; if (halted !== 1'b0) begin fails++; $display("FAIL stall_halted[%0d]: got %b, want 0", i, halted); end
        end
        stall    = 1'b0;
        en_PC    = 1'b1;
        redirect = 1'b0;
        push_exp(16'h1008, 16'h000A);
        @(negedge clk);
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL stall_release_rd: got %b, want 1", imem_rd); end
        tests++; if (imem_addr !== 16'h0008) begin fails++; $display("FAIL stall_release_addr: got %h, want 0008", imem_addr); end
    endtask

    task automatic test_redirect();
        @(negedge clk);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL redir_valid0: got %b, want 1", instr_valid); end
        redirect    = 1'b1;
        redirect_pc = 16'h0005;
        push_exp(16'h1004, 16'h0006);
        @(negedge clk);
        tests++; if (imem_addr !== 16'h0004) begin fails++; $display("FAIL redir_addr4: got %h, want 0004", imem_addr); end
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL redir_rd4: got %b, want 1", imem_rd); end
        // Controls asserted during REQ have no effect.
        redirect_pc = 16'h0777;
        en_PC       = 1'b0;
        stall       = 1'b1;
        @(negedge clk);
        tests++; if (instruc !== 16'h1004) begin fails++; $display("FAIL redir_instr4: got %h, want 1004", instruc); end
        stall       = 1'b0;
        en_PC       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0031;
        push_exp(16'h1030, 16'h0032);
        @(negedge clk);
        tests++; if (imem_addr !== 16'h0030) begin fails++; $display("FAIL redir_addr30: got %h, want 0030", imem_addr); end
        redirect = 1'b0;
        @(negedge clk);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL redir_valid30: got %b, want 1", instr_valid); end
    endtask

    task automatic test_wrap();
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        push_exp(16'h0FFE, 16'h0000);
        @(negedge clk);
        tests++; if (imem_addr !== 16'hFFFE) begin fails++; $display("FAIL wrap_addr: got %h, want fffe", imem_addr); end
        redirect = 1'b0;
        push_exp(16'h1000, 16'h0002);
        @(negedge clk);
        tests++; if (pc_plus2 !== 16'h0000) begin fails++; $display("FAIL wrap_pc_plus2: got %h, want 0000", pc_plus2); end
        @(negedge clk);
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_next_addr: got %h, want 0000", imem_addr); end
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL wrap_next_rd: got %b, want 1", imem_rd); end
        @(negedge clk);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL wrap_valid: got %b, want 1", instr_valid); end
    endtask

    task automatic test_halt();
        en_PC       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_halted[%0d]: got %b, want 1", i, halted); end
            tests++; if (imem_rd !== 1'b0) begin fails++; $display("FAIL halt_rd[%0d]: got %b, want 0", i, imem_rd); end
            tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL halt_valid[%0d]: got %b, want 0", i, instr_valid); end
            en_PC    = 1'b1;
            redirect = 1'b0;
        end
        // Asynchronous reset pulse between clock edges.
        #2 rst = 1'b1;
        #1;
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL halt_rst_halted: got %b, want 0", halted); end
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL halt_rst_rd: got %b, want 1", imem_rd); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL halt_rst_addr: got %h, want 0000", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL halt_rst_valid: got %b, want 0", instr_valid); end
    endtask

    task automatic test_reset_in_hold();
        @(negedge clk);
        rst   = 1'b0;
        stall = 1'b1;
        push_exp(16'h1000, 16'h0002);
        @(negedge clk);
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL hold_valid: got %b, want 1", instr_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL hold_rst_valid: got %b, want 0", instr_valid); end
        tests++; if (instruc !== 16'h0000) begin fails++; $display("FAIL hold_rst_instruc: got %h, want 0000", instruc); end
        tests++; if (pc_plus2 !== 16'h0000) begin fails++; $display("FAIL hold_rst_pc_plus2: got %h, want 0000", pc_plus2); end
        @(negedge clk);
        rst        = 1'b0;
        imem_ready = 1'b0;
        stall      = 1'b0;
        @(negedge clk);
        tests++; if (imem_rd !== 1'b1) begin fails++; $display("FAIL hold_post_rd: got %b, want 1", imem_rd); end
        tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL hold_post_addr: got %h, want 0000", imem_addr); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL hold_post_valid: got %b, want 0", instr_valid); end
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        prev_valid  = 1'b0;
        rst         = 1'b1;
        imem_ready  = 1'b1;
        stall       = 1'b0;
        en_PC       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_in_hold();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_final_drained: got %0d pending, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
